// File: rtl/serdes_pkg.sv
// Shared types and constants for the serializer control slice.
// Holds the two-state FSM encoding, the handshake signal width and the
// mux-select width helper used to size the word counter.
package serdes_pkg;

  // Controller states: IDLE waits for a parallel message, SEND walks its words.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } serializer_state_t;

  // Width of every valid/ready/enable handshake signal.
  localparam int unsigned HS_W = 1;

  // Narrowest select the mux may have, even for single-word messages.
  localparam int unsigned SEL_W_MIN = 1;

  // Select width for a message of n words, never below SEL_W_MIN.
  function automatic int sel_width(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 0;
    return (w > int'(SEL_W_MIN)) ? w : int'(SEL_W_MIN);
  endfunction

endpackage

// File: rtl/word_counter.sv
// Word index counter for the serializer: clear or increment, SEL_W bits wide.
// Latency: count updates on the clock edge after clr/inc is presented.
// Backpressure: none of its own; the controller holds inc low to stall.
//
// Ports:
//   clk   - clock, all updates on rising edge
//   reset - synchronous active-low reset, forces count to 0
//   clr   - return count to 0 (wins over inc)
//   inc   - advance count by one
//   count - current word index
module word_counter #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [SEL_W-1:0] count
);

  // The controller only raises inc below the last index, so no wrap guard
  // is needed here; the addition stays exactly SEL_W bits wide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + SEL_W'(1);
    end
  end

endmodule

// File: rtl/serializer_ctrl.sv
// Serializer control: accepts a parallel message, then emits N_WORDS serial words.
// Latency: first word valid one cycle after acceptance; message period N_WORDS+1.
// Backpressure: send_rdy=0 freezes state and mux_sel; recv_rdy is low throughout SEND.
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   reset     - synchronous active-low reset
//   recv_val  - upstream parallel message valid
//   recv_rdy  - controller can accept a parallel message (high only in IDLE)
//   en_reg    - load enable for the datapath parallel register (recv_val & recv_rdy)
//   mux_sel   - index of the word driven to the serial output
//   send_last - (only with SERIALIZER_CTRL_LAST_EN) final word of the message
//   send_val  - serial word valid downstream
//   send_rdy  - downstream accepts the serial word
//
// Build option: define SERIALIZER_CTRL_LAST_EN to add the send_last output.
module serializer_ctrl
  import serdes_pkg::*;
#(
  parameter int N_WORDS = 8,
  parameter int SEL_W   = sel_width(N_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [HS_W-1:0]  recv_val,
  output logic [HS_W-1:0]  recv_rdy,
  output logic [HS_W-1:0]  en_reg,
  output logic [SEL_W-1:0] mux_sel,
`ifdef SERIALIZER_CTRL_LAST_EN
  output logic             send_last,
`endif
  output logic [HS_W-1:0]  send_val,
  input  logic [HS_W-1:0]  send_rdy
);

  localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(N_WORDS - 1);

  serializer_state_t state;
  serializer_state_t state_nxt;

  logic [SEL_W-1:0] cnt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             last_word;

  word_counter #(
    .SEL_W (SEL_W)
  ) u_word_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign last_word = (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    recv_rdy  = '0;
    send_val  = '0;
    mux_sel   = '0;
    case (state)
      IDLE: begin
        recv_rdy = '1;
        if (recv_val != '0) begin
          state_nxt = SEND;
          cnt_clr   = 1'b1;
        end
      end
      SEND: begin
        // recv_val is deliberately ignored here: no overlap between messages.
        send_val = '1;
        mux_sel  = cnt;
        if (send_rdy != '0) begin
          if (last_word) begin
            // Returning to IDLE costs a cycle, giving the N_WORDS+1 period.
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
    endcase
  end

  assign en_reg = recv_val & recv_rdy;

`ifdef SERIALIZER_CTRL_LAST_EN
  assign send_last = (state == SEND) && last_word;
`endif

endmodule

// File: tb/tb_serializer_ctrl.sv
// Directed bench for serializer_ctrl at N_WORDS = 8, 1 and 4.
// All three instances share one clock; each is driven by its own inputs.
// Expected values are written out by hand per cycle.
module tb_serializer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N_WORDS = 8 instance
  logic       a_reset, a_recv_val, a_recv_rdy, a_en_reg, a_send_val, a_send_rdy;
  logic [2:0] a_mux_sel;
  // N_WORDS = 1 instance
  logic       b_reset, b_recv_val, b_recv_rdy, b_en_reg, b_send_val, b_send_rdy;
  logic [0:0] b_mux_sel;
  // N_WORDS = 4 instance
  logic       c_reset, c_recv_val, c_recv_rdy, c_en_reg, c_send_val, c_send_rdy;
  logic [1:0] c_mux_sel;
`ifdef SERIALIZER_CTRL_LAST_EN
  logic       a_send_last, b_send_last, c_send_last;
`endif

  serializer_ctrl #(.N_WORDS(8)) u_ctrl8 (
    .clk       (clk),
    .reset     (a_reset),
    .recv_val  (a_recv_val),
    .recv_rdy  (a_recv_rdy),
    .en_reg    (a_en_reg),
    .mux_sel   (a_mux_sel),
`ifdef SERIALIZER_CTRL_LAST_EN
    .send_last (a_send_last),
`endif
    .send_val  (a_send_val),
    .send_rdy  (a_send_rdy)
  );

  serializer_ctrl #(.N_WORDS(1)) u_ctrl1 (
    .clk       (clk),
    .reset     (b_reset),
    .recv_val  (b_recv_val),
    .recv_rdy  (b_recv_rdy),
    .en_reg    (b_en_reg),
    .mux_sel   (b_mux_sel),
`ifdef SERIALIZER_CTRL_LAST_EN
    .send_last (b_send_last),
`endif
    .send_val  (b_send_val),
    .send_rdy  (b_send_rdy)
  );

  serializer_ctrl #(.N_WORDS(4)) u_ctrl4 (
    .clk       (clk),
    .reset     (c_reset),
    .recv_val  (c_recv_val),
    .recv_rdy  (c_recv_rdy),
    .en_reg    (c_en_reg),
    .mux_sel   (c_mux_sel),
`ifdef SERIALIZER_CTRL_LAST_EN
    .send_last (c_send_last),
`endif
    .send_val  (c_send_val),
    .send_rdy  (c_send_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string tag, input logic rdy, input logic val,
                         input logic [2:0] sel, input logic last);
    chk({tag, ".recv_rdy"}, 32'(a_recv_rdy), 32'(rdy));
    chk({tag, ".send_val"}, 32'(a_send_val), 32'(val));
    chk({tag, ".mux_sel"},  32'(a_mux_sel),  32'(sel));
    chk({tag, ".en_reg"},   32'(a_en_reg),   32'(a_recv_val & rdy));
`ifdef SERIALIZER_CTRL_LAST_EN
    chk({tag, ".send_last"}, 32'(a_send_last), 32'(last));
`else
    if (last === 1'bx) $display("note: %s", tag);
`endif
  endtask

  task automatic expect1(input string tag, input logic rdy, input logic val);
    chk({tag, ".recv_rdy"}, 32'(b_recv_rdy), 32'(rdy));
    chk({tag, ".send_val"}, 32'(b_send_val), 32'(val));
    chk({tag, ".mux_sel"},  32'(b_mux_sel),  32'd0);
    chk({tag, ".en_reg"},   32'(b_en_reg),   32'(b_recv_val & rdy));
`ifdef SERIALIZER_CTRL_LAST_EN
    chk({tag, ".send_last"}, 32'(b_send_last), 32'(val));
`endif
  endtask

  task automatic expect4(input string tag, input logic rdy, input logic val,
                         input logic [1:0] sel, input logic last);
    chk({tag, ".recv_rdy"}, 32'(c_recv_rdy), 32'(rdy));
    chk({tag, ".send_val"}, 32'(c_send_val), 32'(val));
    chk({tag, ".mux_sel"},  32'(c_mux_sel),  32'(sel));
    chk({tag, ".en_reg"},   32'(c_en_reg),   32'(c_recv_val & rdy));
`ifdef SERIALIZER_CTRL_LAST_EN
    chk({tag, ".send_last"}, 32'(c_send_last), 32'(last));
`else
    if (last === 1'bx) $display("note: %s", tag);
`endif
  endtask

  initial begin
    a_reset = 1'b0; a_recv_val = 1'b1; a_send_rdy = 1'b0;
    b_reset = 1'b0; b_recv_val = 1'b0; b_send_rdy = 1'b0;
    c_reset = 1'b0; c_recv_val = 1'b0; c_send_rdy = 1'b0;

    // Reset held for two edges with recv_val high: reset wins, no SEND entry.
    tick(); expect8("rst1", 1, 0, 3'd0, 0);
    tick(); expect8("rst2", 1, 0, 3'd0, 0);
    a_reset = 1'b1; a_recv_val = 1'b0; a_send_rdy = 1'b1;
    #1 expect8("idle", 1, 0, 3'd0, 0);

    // Full message with send_rdy held high; recv_val kept high must be ignored.
    a_recv_val = 1'b1;
    #1 expect8("acc", 1, 0, 3'd0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      expect8($sformatf("word%0d", k), 0, 1, 3'(k), k == 7);
      tick();
    end
    // Cycle t+9: back in IDLE, and recv_val still high is accepted here.
    expect8("done", 1, 0, 3'd0, 0);

    // Backpressure: 3 stalls at word 3, 2 stalls at the last word.
    tick();
    a_recv_val = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int stalls;
      stalls = (k == 3) ? 3 : ((k == 7) ? 2 : 0);
      a_send_rdy = 1'b0;
      for (int s = 0; s < stalls; s++) begin
        #1 expect8($sformatf("stall%0d_%0d", k, s), 0, 1, 3'(k), k == 7);
        tick();
      end
      a_send_rdy = 1'b1;
      #1 expect8($sformatf("bp%0d", k), 0, 1, 3'(k), k == 7);
      tick();
    end
    expect8("bp_done", 1, 0, 3'd0, 0);

    // Reset mid-message at word 5, then a fresh message restarts at word 0.
    a_recv_val = 1'b1;
    tick();
    a_recv_val = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    expect8("pre_rst", 0, 1, 3'd5, 0);
    a_reset = 1'b0;
    tick();
    a_reset = 1'b1;
    #1 expect8("post_rst", 1, 0, 3'd0, 0);
    a_recv_val = 1'b1;
    tick();
    a_recv_val = 1'b0;
    expect8("restart0", 0, 1, 3'd0, 0);
    tick();
    expect8("restart1", 0, 1, 3'd1, 0);

    // N_WORDS = 1: one handshake per message, 2-cycle period.
    b_reset = 1'b1; b_recv_val = 1'b1; b_send_rdy = 1'b1;
    #1 expect1("n1_idle", 1, 0);
    tick(); expect1("n1_send_a", 0, 1);
    tick(); expect1("n1_idle_a", 1, 0);
    tick(); expect1("n1_send_b", 0, 1);
    b_send_rdy = 1'b0;
    tick(); expect1("n1_stall", 0, 1);
    b_send_rdy = 1'b1; b_recv_val = 1'b0;
    tick(); expect1("n1_idle_b", 1, 0);
    tick(); expect1("n1_stay", 1, 0);

    // N_WORDS = 4: 2-bit select reaches 3 and returns to IDLE without wrapping.
    c_reset = 1'b1; c_recv_val = 1'b1; c_send_rdy = 1'b1;
    tick();
    c_recv_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect4($sformatf("n4_word%0d", k), 0, 1, 2'(k), k == 3);
      tick();
    end
    expect4("n4_done", 1, 0, 2'd0, 0);
    tick();
    expect4("n4_stay", 1, 0, 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
